// File: rtl/ozphy_pkg.sv
// Shared symbol codes and receive ordered-set FSM states for the PHY receive path.
package ozphy_pkg;

  localparam logic [7:0] COM   = 8'hBC;
  localparam logic [7:0] SKP   = 8'h1C;
  localparam logic [7:0] PAD   = 8'hF7;
  localparam logic [7:0] TS1ID = 8'h4A;
  localparam logic [7:0] TS2ID = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COM_SEEN,
    S_SKP,
    S_TS_HDR,
    S_TS_ID
  } os_state_t;

endpackage

// File: rtl/rx_os_sat_cnt.sv
// Saturating counter with clear / load-one / increment controls (priority in that order).
module rx_os_sat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             load1,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CNT_W'(1);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rx_os_detector.sv
// Receive-side detector for SKP, TS1 and TS2 ordered sets with consecutive-TS counting.
module rx_os_detector
  import ozphy_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int SKP_SYMS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rxdata,
  input  logic             rxdatak,
  input  logic             rxvalid,
  output logic             skp_det,
  output logic             ts1_det,
  output logic             ts2_det,
  output logic [39:0]      ts_fields,
  output logic [CNT_W-1:0] ts1_cnt,
  output logic [CNT_W-1:0] ts2_cnt,
  output logic             os_err
);

  localparam logic [7:0] SKP_LAST = 8'(SKP_SYMS);

  os_state_t   state, next_state;
  logic [3:0]  sym_idx;
  logic [7:0]  skp_cnt;
  logic [39:0] shadow;
  logic [39:0] prev_ts1, prev_ts2;
  logic        ts_is_ts2;

  logic k_com, k_skp;
  logic skp_hit_p0, ts1_hit_p0, ts2_hit_p0, err_hit_p0;
  logic cap_en_p0, id_we_p0;

  assign k_com = rxdatak && (rxdata == COM);
  assign k_skp = rxdatak && (rxdata == SKP);

  always_comb begin
    next_state = state;
    skp_hit_p0 = 1'b0;
    ts1_hit_p0 = 1'b0;
    ts2_hit_p0 = 1'b0;
    err_hit_p0 = 1'b0;
    cap_en_p0  = 1'b0;
    id_we_p0   = 1'b0;
    if (!rxvalid) begin
      next_state = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (k_com) next_state = S_COM_SEEN;
        S_COM_SEEN: begin
          if (k_skp) begin
            if (SKP_SYMS <= 1) begin
              skp_hit_p0 = 1'b1;
              next_state = S_IDLE;
            end else begin
              next_state = S_SKP;
            end
          end else if (!k_com) begin
            cap_en_p0  = 1'b1;
            next_state = S_TS_HDR;
          end
        end
        S_SKP: begin
          if (k_skp) begin
            if (skp_cnt + 8'd1 >= SKP_LAST) begin
              skp_hit_p0 = 1'b1;
              next_state = S_IDLE;
            end
          end else begin
            err_hit_p0 = 1'b1;
            next_state = k_com ? S_COM_SEEN : S_IDLE;
          end
        end
        S_TS_HDR: begin
          if (k_com) begin
            err_hit_p0 = 1'b1;
            next_state = S_COM_SEEN;
          end else begin
            cap_en_p0 = 1'b1;
            if (sym_idx == 4'd5) next_state = S_TS_ID;
          end
        end
        S_TS_ID: begin
          if (k_com) begin
            err_hit_p0 = 1'b1;
            next_state = S_COM_SEEN;
          end else if (sym_idx == 4'd6) begin
            if (!rxdatak && (rxdata == TS1ID || rxdata == TS2ID)) begin
              id_we_p0 = 1'b1;
            end else begin
              err_hit_p0 = 1'b1;
              next_state = S_IDLE;
            end
          end else if (rxdatak || rxdata != (ts_is_ts2 ? TS2ID : TS1ID)) begin
            err_hit_p0 = 1'b1;
            next_state = S_IDLE;
          end else if (sym_idx == 4'd15) begin
            ts1_hit_p0 = !ts_is_ts2;
            ts2_hit_p0 = ts_is_ts2;
            next_state = S_IDLE;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: registered pulses, field capture and counter updates
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      sym_idx   <= '0;
      skp_cnt   <= '0;
      shadow    <= '0;
      prev_ts1  <= '0;
      prev_ts2  <= '0;
      ts_fields <= '0;
      ts_is_ts2 <= 1'b0;
      skp_det   <= 1'b0;
      ts1_det   <= 1'b0;
      ts2_det   <= 1'b0;
      os_err    <= 1'b0;
    end else begin
      state   <= next_state;
      skp_det <= skp_hit_p0;
      ts1_det <= ts1_hit_p0;
      ts2_det <= ts2_hit_p0;
      os_err  <= err_hit_p0;
      if (rxvalid) begin
        if (state == S_COM_SEEN) begin
          sym_idx <= 4'd2;
          skp_cnt <= 8'd1;
        end else begin
          sym_idx <= sym_idx + 4'd1;
          if (k_skp) skp_cnt <= skp_cnt + 8'd1;
        end
      end
      // Fields arrive in order, so a right shift leaves symbol 1 in the low byte
      if (cap_en_p0) shadow <= {rxdata, shadow[39:8]};
      if (id_we_p0)  ts_is_ts2 <= (rxdata == TS2ID);
      if (ts1_hit_p0) begin
        ts_fields <= shadow;
        prev_ts1  <= shadow;
      end
      if (ts2_hit_p0) begin
        ts_fields <= shadow;
        prev_ts2  <= shadow;
      end
    end
  end

  logic ts1_inc, ts1_load, ts1_clr;
  logic ts2_inc, ts2_load, ts2_clr;

  assign ts1_inc  = ts1_hit_p0 && (shadow == prev_ts1) && (ts1_cnt != '0);
  assign ts1_load = ts1_hit_p0 && !ts1_inc;
  assign ts1_clr  = err_hit_p0 || ts2_hit_p0 || !rxvalid;
  assign ts2_inc  = ts2_hit_p0 && (shadow == prev_ts2) && (ts2_cnt != '0);
  assign ts2_load = ts2_hit_p0 && !ts2_inc;
  assign ts2_clr  = err_hit_p0 || ts1_hit_p0 || !rxvalid;

  rx_os_sat_cnt #(.CNT_W(CNT_W)) u_ts1_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ts1_inc),
    .load1   (ts1_load),
    .clear   (ts1_clr),
    .cnt     (ts1_cnt)
  );

  rx_os_sat_cnt #(.CNT_W(CNT_W)) u_ts2_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (ts2_inc),
    .load1   (ts2_load),
    .clear   (ts2_clr),
    .cnt     (ts2_cnt)
  );

endmodule

// File: tb/tb_rx_os_detector.sv
// Directed bench for rx_os_detector: SKP, TS1/TS2 trains, malformed sets, rxvalid drop, reset.
module tb_rx_os_detector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rxdata;
  logic        rxdatak;
  logic        rxvalid;
  logic        skp_det, ts1_det, ts2_det, os_err;
  logic [39:0] ts_fields;
  logic [3:0]  ts1_cnt, ts2_cnt;
  logic [3:0]  pv;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign pv = {skp_det, ts1_det, ts2_det, os_err};

  rx_os_detector #(.CNT_W(4), .SKP_SYMS(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxdata    (rxdata),
    .rxdatak   (rxdatak),
    .rxvalid   (rxvalid),
    .skp_det   (skp_det),
    .ts1_det   (ts1_det),
    .ts2_det   (ts2_det),
    .ts_fields (ts_fields),
    .ts1_cnt   (ts1_cnt),
    .ts2_cnt   (ts2_cnt),
    .os_err    (os_err)
  );

  // Drive at a falling edge; on return the symbol has been sampled and its result is visible.
  task automatic sym(input logic k, input logic [7:0] d);
    rxdatak = k;
    rxdata  = d;
    rxvalid = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_ts(input logic [39:0] f, input logic fk, input logic [7:0] id,
                         input int last_idx, input int bad_idx, input logic [7:0] bad_val,
                         output int early);
    logic       k;
    logic [7:0] d;
    early = 0;
    for (int i = 0; i <= last_idx; i++) begin
      if (i == 0) begin k = 1'b1; d = 8'hBC; end
      else if (i <= 5) begin k = fk; d = f[(i-1)*8 +: 8]; end
      else begin k = 1'b0; d = id; end
      if (i == bad_idx) begin k = 1'b0; d = bad_val; end
      sym(k, d);
      if (i < last_idx && pv != 4'b0000) early++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; rxvalid = 1'b0; rxdata = 8'h00; rxdatak = 1'b0;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if ({pv, ts_fields, ts1_cnt, ts2_cnt} !== 52'h0) begin
      tests_failed++;
      $display("FAIL reset_state: pulses=%b fields=%h c1=%0d c2=%0d required all zero", pv, ts_fields, ts1_cnt, ts2_cnt);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_skp;
    sym(1'b0, 8'h00); sym(1'b1, 8'hBC); sym(1'b1, 8'h1C); sym(1'b1, 8'h1C);
    tests_run++;
    if (pv !== 4'b0000) begin tests_failed++; $display("FAIL skp_early: pulses=%b required 0000", pv); end
    sym(1'b1, 8'h1C);
    tests_run++;
    if (pv !== 4'b1000) begin tests_failed++; $display("FAIL skp_det: pulses=%b required 1000", pv); end
    sym(1'b0, 8'h00);
    tests_run++;
    if ({pv, ts1_cnt, ts2_cnt} !== 12'h000) begin
      tests_failed++; $display("FAIL skp_after: pulses=%b c1=%0d c2=%0d required 0000 0 0", pv, ts1_cnt, ts2_cnt);
    end
  endtask

  task automatic test_ts1_train;
    int early;
    for (int n = 1; n <= 3; n++) begin
      send_ts(40'h0504030201, 1'b0, 8'h4A, 15, -1, 8'h00, early);
      tests_run++;
      if (early !== 0 || pv !== 4'b0100 || ts1_cnt !== 4'(n) || ts_fields !== 40'h0504030201) begin
        tests_failed++;
        $display("FAIL ts1_train_%0d: early=%0d pulses=%b c1=%0d fields=%h required 0 0100 %0d 0504030201", n, early, pv, ts1_cnt, ts_fields, n);
      end
    end
    sym(1'b1, 8'hBC); sym(1'b1, 8'h1C); sym(1'b1, 8'h1C); sym(1'b1, 8'h1C);
    tests_run++;
    if (pv !== 4'b1000 || ts1_cnt !== 4'd3) begin
      tests_failed++; $display("FAIL skp_in_train: pulses=%b c1=%0d required 1000 3", pv, ts1_cnt);
    end
    send_ts(40'h0504030201, 1'b0, 8'h4A, 15, -1, 8'h00, early);
    tests_run++;
    if (pv !== 4'b0100 || ts1_cnt !== 4'd4) begin
      tests_failed++; $display("FAIL ts1_after_skp: pulses=%b c1=%0d required 0100 4", pv, ts1_cnt);
    end
  endtask

  task automatic test_ts2;
    int early;
    send_ts(40'h0504030201, 1'b0, 8'h4A, 15, -1, 8'h00, early);
    send_ts(40'h0504030201, 1'b0, 8'h4A, 15, -1, 8'h00, early);
    tests_run++;
    if (ts1_cnt !== 4'd6) begin tests_failed++; $display("FAIL ts1_pre_ts2: c1=%0d required 6", ts1_cnt); end
    send_ts(40'hF7F7F7F7F7, 1'b1, 8'h45, 15, -1, 8'h00, early);
    tests_run++;
    if (pv !== 4'b0010 || ts2_cnt !== 4'd1 || ts1_cnt !== 4'd0 || ts_fields !== 40'hF7F7F7F7F7) begin
      tests_failed++;
      $display("FAIL ts2_det: pulses=%b c2=%0d c1=%0d fields=%h required 0010 1 0 f7f7f7f7f7", pv, ts2_cnt, ts1_cnt, ts_fields);
    end
    send_ts(40'h0504030201, 1'b0, 8'h45, 15, -1, 8'h00, early);
    tests_run++;
    if (ts2_cnt !== 4'd1) begin tests_failed++; $display("FAIL ts2_new_fields: c2=%0d required 1", ts2_cnt); end
    send_ts(40'h0504030201, 1'b0, 8'h45, 15, -1, 8'h00, early);
    tests_run++;
    if (ts2_cnt !== 4'd2) begin tests_failed++; $display("FAIL ts2_repeat: c2=%0d required 2", ts2_cnt); end
  endtask

  task automatic test_ts_err;
    int early;
    int late = 0;
    send_ts(40'h0504030201, 1'b0, 8'h4A, 9, 9, 8'h45, early);
    tests_run++;
    if (early !== 0 || pv !== 4'b0001 || ts1_cnt !== 4'd0 || ts2_cnt !== 4'd0 || ts_fields !== 40'h0504030201) begin
      tests_failed++;
      $display("FAIL ts_id_err: early=%0d pulses=%b c1=%0d c2=%0d fields=%h required 0 0001 0 0 0504030201", early, pv, ts1_cnt, ts2_cnt, ts_fields);
    end
    for (int i = 10; i <= 15; i++) begin
      sym(1'b0, 8'h4A);
      if (pv !== 4'b0000) late++;
    end
    tests_run++;
    if (late !== 0) begin tests_failed++; $display("FAIL ts_err_tail: pulses_seen=%0d required 0", late); end
  endtask

  task automatic test_skp_err;
    sym(1'b1, 8'hBC); sym(1'b1, 8'h1C); sym(1'b1, 8'hBC);
    tests_run++;
    if (pv !== 4'b0001) begin tests_failed++; $display("FAIL skp_com_err: pulses=%b required 0001", pv); end
    sym(1'b1, 8'h1C); sym(1'b1, 8'h1C); sym(1'b1, 8'h1C);
    tests_run++;
    if (pv !== 4'b1000) begin tests_failed++; $display("FAIL skp_after_err: pulses=%b required 1000", pv); end
  endtask

  task automatic test_bad_id;
    int early;
    send_ts(40'h1122334455, 1'b0, 8'h4A, 6, 6, 8'h00, early);
    tests_run++;
    if (early !== 0 || pv !== 4'b0001) begin
      tests_failed++; $display("FAIL bad_id: early=%0d pulses=%b required 0 0001", early, pv);
    end
  endtask

  task automatic test_com_in_ts;
    int early;
    sym(1'b1, 8'hBC); sym(1'b0, 8'h0E); sym(1'b0, 8'h0D); sym(1'b1, 8'hBC);
    tests_run++;
    if (pv !== 4'b0001) begin tests_failed++; $display("FAIL com_in_hdr: pulses=%b required 0001", pv); end
    // Restart from COM_SEEN: skip the leading COM of the helper by sending it inline.
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      if (i <= 5) sym(1'b0, 8'(8'h0F - i)); else sym(1'b0, 8'h4A);
      if (i < 15 && pv !== 4'b0000) early++;
    end
    tests_run++;
    if (early !== 0 || pv !== 4'b0100 || ts1_cnt !== 4'd1 || ts_fields !== 40'h0A0B0C0D0E) begin
      tests_failed++;
      $display("FAIL restart_ts1: early=%0d pulses=%b c1=%0d fields=%h required 0 0100 1 0a0b0c0d0e", early, pv, ts1_cnt, ts_fields);
    end
  endtask

  task automatic test_rxvalid_drop;
    int early;
    int late = 0;
    send_ts(40'h0A0B0C0D0E, 1'b0, 8'h4A, 15, -1, 8'h00, early);
    tests_run++;
    if (ts1_cnt !== 4'd2) begin tests_failed++; $display("FAIL ts1_cnt_two: c1=%0d required 2", ts1_cnt); end
    send_ts(40'h0A0B0C0D0E, 1'b0, 8'h4A, 7, -1, 8'h00, early);
    rxvalid = 1'b0; rxdata = 8'h4A; rxdatak = 1'b0;
    @(negedge clk);
    tests_run++;
    if (pv !== 4'b0000 || ts1_cnt !== 4'd0 || ts_fields !== 40'h0A0B0C0D0E) begin
      tests_failed++;
      $display("FAIL rxvalid_drop: pulses=%b c1=%0d fields=%h required 0000 0 0a0b0c0d0e", pv, ts1_cnt, ts_fields);
    end
    for (int i = 8; i <= 15; i++) begin
      sym(1'b0, 8'h4A);
      if (pv !== 4'b0000) late++;
    end
    tests_run++;
    if (late !== 0) begin tests_failed++; $display("FAIL drop_tail: pulses_seen=%0d required 0", late); end
  endtask

  task automatic test_saturation;
    int early;
    for (int n = 1; n <= 16; n++) begin
      send_ts(40'h0102030405, 1'b0, 8'h4A, 15, -1, 8'h00, early);
      if (n >= 15) begin
        tests_run++;
        if (ts1_cnt !== 4'd15) begin
          tests_failed++; $display("FAIL ts1_saturate_%0d: c1=%0d required 15", n, ts1_cnt);
        end
      end
    end
  endtask

  task automatic test_reset_mid_skp;
    sym(1'b1, 8'hBC); sym(1'b1, 8'h1C);
    reset_n = 1'b0;
    sym(1'b1, 8'h1C);
    tests_run++;
    if ({pv, ts_fields, ts1_cnt, ts2_cnt} !== 52'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_skp: pulses=%b fields=%h c1=%0d c2=%0d required all zero", pv, ts_fields, ts1_cnt, ts2_cnt);
    end
    reset_n = 1'b1;
    sym(1'b1, 8'h1C);
    tests_run++;
    if (pv !== 4'b0000) begin tests_failed++; $display("FAIL skp_discarded: pulses=%b required 0000", pv); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_skp();
    test_ts1_train();
    test_ts2();
    test_ts_err();
    test_skp_err();
    test_bad_id();
    test_com_in_ts();
    test_rxvalid_drop();
    test_saturation();
    test_reset_mid_skp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rx_os_detector.md
RX_OS_DETECTOR -- requirements
Module: rx_os_detector

Interface
REQ-001 SHALL have parameter CNT_W, default 4: width of consecutive-TS counters.
REQ-002 SHALL have parameter SKP_SYMS, default 3: SKP symbols following COM in a SKP ordered set.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 rxdata  input  8  received symbol.
REQ-006 rxdatak  input  1  symbol is a K-character.
REQ-007 rxvalid  input  1  symbol valid.
REQ-008 skp_det  output  1  one-cycle pulse: complete SKP set received.
REQ-009 ts1_det  output  1  one-cycle pulse: complete TS1 received.
REQ-010 ts2_det  output  1  one-cycle pulse: complete TS2 received.
REQ-011 ts_fields  output  40  symbols 1..5 of last complete TS; symbol 1 in [7:0], symbol 5 in [39:32].
REQ-012 ts1_cnt  output  CNT_W  consecutive identical TS1 count.
REQ-013 ts2_cnt  output  CNT_W  consecutive identical TS2 count.
REQ-014 os_err  output  1  one-cycle pulse: malformed ordered set.

Function
REQ-015 SHALL sample a symbol only when rxvalid=1 on posedge clk.
REQ-016 FSM states IDLE, COM_SEEN, SKP, TS_HDR, TS_ID.
REQ-017 IDLE: K BC -> COM_SEEN; any other symbol ignored, no error (incl. idle 00).
REQ-018 COM_SEEN: K 1C -> SKP (SKP count 1); K BC -> stays COM_SEEN; otherwise symbol captured as field symbol 1 -> TS_HDR.
REQ-019 SKP: each K 1C increments count; on count reaching SKP_SYMS, skp_det pulses next cycle, -> IDLE.
REQ-020 SKP: non-SKP symbol before SKP_SYMS -> os_err, -> COM_SEEN if K BC else IDLE.
REQ-021 TS_HDR: captures symbols 2..5 into shadow field register; after symbol 5 -> TS_ID.
REQ-022 TS_ID: symbol 6 D 4A selects TS1, D 45 selects TS2, else os_err -> IDLE; symbols 7..15 must equal symbol 6 ID, else os_err -> IDLE.
REQ-023 Any K BC in TS_HDR/TS_ID SHALL raise os_err and restart at COM_SEEN.
REQ-024 On symbol 15 valid: ts1_det or ts2_det pulses next cycle; ts_fields loads shadow fields same cycle as pulse; -> IDLE.
REQ-025 Completed TS1: ts1_cnt increments if fields equal previous completed TS1 fields and ts1_cnt nonzero, else loads 1; ts2_cnt clears.
REQ-026 Completed TS2: symmetric to REQ-025 with roles swapped.
REQ-027 Counters SHALL saturate at 2^CNT_W-1.
REQ-028 skp_det SHALL not alter ts1_cnt/ts2_cnt (SKP may interleave TS trains).
REQ-029 os_err SHALL clear ts1_cnt and ts2_cnt.
REQ-030 rxvalid=0 SHALL return FSM to IDLE, clear both counters, no os_err; ts_fields held.
REQ-031 Latency: detect/error pulse exactly one cycle after sampling the deciding symbol.
REQ-032 At most one of skp_det, ts1_det, ts2_det, os_err asserted per cycle.
REQ-033 Back-to-back sets with no gap SHALL all be detected.

Reset
REQ-034 reset_n=0 at posedge clk: FSM IDLE, all pulses 0, ts_fields 0, ts1_cnt 0, ts2_cnt 0, shadow/previous-field registers 0.
REQ-035 Reset mid-set SHALL discard the partial set with no pulse.

Structure
REQ-036 Shared package ozphy_pkg SHALL hold COM 8'hBC, SKP 8'h1C, PAD 8'hF7, TS1ID 8'h4A, TS2ID 8'h45 and FSM state enum.
REQ-037 Sub-module rx_os_sat_cnt (CNT_W saturating counter, inc/load1/clear) SHALL be instantiated twice.

Verification
REQ-038 COM,1C,1C,1C (K) -> skp_det one cycle after last 1C; counters unchanged.
REQ-039 TS1 fields 01,02,03,04,05 then ten 4A, repeated 3x back-to-back -> ts1_det x3, ts1_cnt 1,2,3, ts_fields 40'h0504030201.
REQ-040 Two TS1 then TS2 (fields F7x5) -> ts2_det, ts2_cnt 1, ts1_cnt 0.
REQ-041 TS1 with symbol 9 = 45 -> os_err one cycle later, counters 0, no ts1_det.
REQ-042 COM,1C then COM -> os_err; following 1C,1C,1C -> skp_det.
REQ-043 rxvalid low mid-TS1 after ts1_cnt=2 -> no pulse, ts1_cnt 0; reset_n low mid-SKP -> all outputs 0.
